// File: rtl/key_sched_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : key_sched_ctrl_if
// Purpose  : Key-load, expansion-engine and round-key request signals of
//            the AES-256 key scheduler.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface key_sched_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic [255:0]     key_i;
  logic             key_load_i;
  logic             busy_o;
  logic             key_ready_o;
  logic             kx_start_o;
  logic [255:0]     kx_key_o;
  logic             kx_valid_i;
  logic [127:0]     kx_rkey_i;
  logic             rk_req_i;
  logic [IDX_W-1:0] rk_idx_i;
  logic             rk_valid_o;
  logic [127:0]     rk_data_o;
  logic             rk_err_o;

  modport slave (
    input  key_i, key_load_i, kx_valid_i, kx_rkey_i, rk_req_i, rk_idx_i,
    output busy_o, key_ready_o, kx_start_o, kx_key_o, rk_valid_o, rk_data_o, rk_err_o
  );

  modport master (
    output key_i, key_load_i, kx_valid_i, kx_rkey_i, rk_req_i, rk_idx_i,
    input  busy_o, key_ready_o, kx_start_o, kx_key_o, rk_valid_o, rk_data_o, rk_err_o
  );
endinterface
`default_nettype wire

// File: rtl/key_sched_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : key_sched_ctrl
// Purpose  : AES-256 round-key scheduler: drives the expansion engine,
//            stores the 15 round keys and serves them by round index.
// Revision : 1.0
// ---------------------------------------------------------------------------
module key_sched_ctrl #(
  parameter int unsigned NRK   = 15,
  parameter int unsigned IDX_W = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  key_sched_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_READY = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NRK - 1);
  localparam logic [IDX_W:0]   NRK_EXT  = (IDX_W + 1)'(NRK);

  state_t           state_q;
  logic [IDX_W-1:0] wr_ptr_q;
  logic [127:0]     mem_q [NRK];
  logic [255:0]     kx_key_q;
  logic             kx_start_q;
  logic             busy_q;
  logic             key_ready_q;
  logic             rk_valid_q;
  logic             rk_err_q;
  logic [127:0]     rk_data_q;

  logic             rk_hit;
  logic             rk_valid_d;
  logic             rk_err_d;

  // Requests see the state of the sampling cycle, so a request coinciding
  // with key_load in READY is still served from the previous schedule.
  assign rk_hit     = (state_q == S_READY) && ({1'b0, bus.rk_idx_i} < NRK_EXT);
  assign rk_valid_d = bus.rk_req_i && rk_hit;
  assign rk_err_d   = bus.rk_req_i && !rk_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      kx_key_q    <= '0;
      kx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_err_q    <= 1'b0;
      rk_data_q   <= '0;
      for (int i = 0; i < int'(NRK); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rk_valid_q <= rk_valid_d;
      rk_err_q   <= rk_err_d;
      if (rk_valid_d) begin
        rk_data_q <= mem_q[bus.rk_idx_i];
      end

      kx_start_q <= 1'b0;
      if (bus.key_load_i) begin
        // A new key pre-empts everything, including a running expansion.
        kx_key_q    <= bus.key_i;
        state_q     <= S_LOAD;
        kx_start_q  <= 1'b1;
        busy_q      <= 1'b1;
        key_ready_q <= 1'b0;
        wr_ptr_q    <= '0;
      end else begin
        case (state_q)
          S_LOAD: begin
            wr_ptr_q <= '0;
            state_q  <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.kx_valid_i) begin
              mem_q[wr_ptr_q] <= bus.kx_rkey_i;
              wr_ptr_q        <= wr_ptr_q + IDX_W'(1);
              if (wr_ptr_q == LAST_IDX) begin
                state_q     <= S_READY;
                busy_q      <= 1'b0;
                key_ready_q <= 1'b1;
              end
            end
          end
          S_IDLE, S_READY: begin
            state_q <= state_q;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.key_ready_o = key_ready_q;
  assign bus.kx_start_o  = kx_start_q;
  assign bus.kx_key_o    = kx_key_q;
  assign bus.rk_valid_o  = rk_valid_q;
  assign bus.rk_err_o    = rk_err_q;
  assign bus.rk_data_o   = rk_data_q;

endmodule
`default_nettype wire

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

AES-256 round-key scheduler/controller for the CTR datapath. On a new cipher key it starts the key-expansion engine, captures the 15 streamed 128-bit round keys into a local register file, and then serves round keys to the cipher core by round index through a request/response port. It owns the engine handshake and blocks cipher access while expansion is in flight.

## Interface

- NRK, 15, number of round keys stored (AES-256: rounds 0..14)
- IDX_W, 4, round-index width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- key  in  256  cipher key; sampled only on key_load
- key_load  in  1  one-cycle pulse: start a new expansion
- busy  out  1  high in LOAD/WAIT
- key_ready  out  1  high in READY; all NRK round keys valid
- kx_start  out  1  one-cycle start pulse to the expansion engine
- kx_key  out  256  registered copy of key driven to the engine
- kx_valid  in  1  engine round-key strobe, one per key, in order 0..14
- kx_rkey  in  128  round key qualified by kx_valid
- rk_req  in  1  cipher round-key request
- rk_idx  in  IDX_W  requested round index
- rk_valid  out  1  one-cycle response strobe, data valid
- rk_data  out  128  round key for the accepted request
- rk_err  out  1  one-cycle strobe: request rejected

## Operation

- FSM states: IDLE, LOAD, WAIT, READY.
- IDLE: on key_load, kx_key <= key, go LOAD.
- LOAD, one cycle: kx_start=1, wr_ptr <= 0, go WAIT.
- WAIT: each cycle with kx_valid=1, mem[wr_ptr] <= kx_rkey and wr_ptr++. When kx_valid=1 with wr_ptr==NRK-1, go READY. No timeout; the controller waits indefinitely.
- READY: key_ready=1, hold until key_load.
- key_load in any state, including LOAD, WAIT, or READY: recapture key and go LOAD. A partial expansion is abandoned, wr_ptr restarts at 0, and key_ready/busy update the next cycle.
- kx_valid outside WAIT is ignored. So is kx_valid in the same cycle as key_load.
- Requests are evaluated against the state in the sampling cycle:
  - If state==READY and rk_idx<NRK: rk_valid=1, rk_data=mem[rk_idx].
  - Otherwise: rk_err=1 and rk_data holds its previous value.
- rk_req and key_load in the same READY cycle: the request is served from the old keys (memory is not yet overwritten); key_load takes effect for the FSM.
- Back-to-back requests are allowed, one per cycle, with no backpressure.
- Outputs kx_start, busy, key_ready, rk_valid, rk_err, and rk_data are all registered.

## Timing

- Reset (rst=0, asynchronous): state=IDLE, wr_ptr=0, mem cleared to 0.
  - All outputs 0: busy, key_ready, kx_start, kx_key, rk_valid, rk_data, rk_err.
  - Release is synchronous to the next clk edge.
- key_load sampled at edge N: LOAD during cycle N+1 (kx_start=1, busy=1); WAIT from cycle N+2.
- Engine delivering one key per cycle from cycle N+2: last key sampled at edge N+16, key_ready=1 from cycle N+17, busy=0 the same cycle.
- Request latency: rk_req sampled at edge M, rk_valid or rk_err high during cycle M+1 only.
- Exactly one of rk_valid/rk_err is high per accepted rk_req; neither is high without rk_req.
- Reset asserted mid-WAIT: immediate return to IDLE with all stored keys cleared. The engine is not notified; its subsequent kx_valid is ignored.

## Test plan

- Reset, then key=000102…1f and key_load; engine model streams the FIPS-197 AES-256 schedule one key per cycle. Expect:
  - kx_start high for exactly one cycle.
  - key_ready 15 cycles after the first kx_valid.
  - rk_idx=0 returns 000102030405060708090a0b0c0d0e0f.
  - rk_idx=2 returns a573c29fa176c498a97fce93a572c09c.
- rk_req while busy (WAIT, after 5 keys stored) -> rk_err=1 next cycle, rk_valid=0, rk_data unchanged. rk_idx=15 in READY -> rk_err=1.
- Engine inserts kx_valid gaps (valid every 3rd cycle) -> key_ready only after the 15th strobe. All 15 indices read back in order, back-to-back, one rk_valid per cycle.
- key_load after the 7th round key of key A, then key B streamed -> second kx_start pulse. Every index returns key B's schedule; no key A data remains.
- In READY, rk_req(idx=14) in the same cycle as key_load -> old key's round 14 returned; key_ready=0 and busy=1 next cycle.
- Assert rst for one cycle mid-WAIT -> all outputs 0 immediately. Stray kx_valid afterwards is ignored; rk_req after release -> rk_err.
